// File: rtl/debug_led_pager_if.sv
// Signal bundle between datapath debug sources and the paged LED driver.
// page_next is a one-cycle strobe with no ready: it is either consumed on the
// edge it is seen (advance) or dropped (freeze); levels auto_scroll/freeze are sampled every edge.
interface debug_led_pager_if #(
  parameter int NUM_CH = 4,
  parameter int LED_W  = 16
);
  localparam int PAGE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*LED_W-1:0] ch_data;
  logic                    page_next;
  logic                    auto_scroll;
  logic                    freeze;
  logic [LED_W-1:0]        led;
  logic [PAGE_W-1:0]       page_idx;

  modport master (
    output ch_data, page_next, auto_scroll, freeze,
    input  led, page_idx
  );

  modport slave (
    input  ch_data, page_next, auto_scroll, freeze,
    output led, page_idx
  );
endinterface

// File: rtl/debug_led_pager.sv
// Paged debug-LED driver: selects one of NUM_CH debug words, stretches chosen
// bits so single-cycle events stay visible, and supports auto-scroll and freeze.
module debug_led_pager #(
  parameter int                NUM_CH         = 4,
  parameter int                LED_W          = 16,
  parameter logic [LED_W-1:0]  STRETCH_MASK   = 16'h9000,
  parameter int                STRETCH_CYCLES = 5_000_000,
  parameter int                SCROLL_CYCLES  = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  debug_led_pager_if.slave  bus
);
  localparam int PAGE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = $clog2(STRETCH_CYCLES + 1);
  localparam int SCR_W  = $clog2(SCROLL_CYCLES);

  logic [PAGE_W-1:0] page_q;
  logic [PAGE_W-1:0] page_nxt;
  logic [SCR_W-1:0]  scroll_q;
  logic [LED_W-1:0]  led_q;
  logic [LED_W-1:0]  led_nxt;
  logic [LED_W-1:0]  raw;
  logic [LED_W-1:0]  new_raw;
  logic              scroll_term;
  logic              adv;

  assign scroll_term = bus.auto_scroll && (scroll_q == SCR_W'(SCROLL_CYCLES - 1));
  // A manual pulse coinciding with the terminal count still yields one step.
  assign adv         = !bus.freeze && (bus.page_next || scroll_term);

  always_comb begin
    page_nxt = page_q;
    if (NUM_CH > 1) begin
      if (page_q == PAGE_W'(NUM_CH - 1)) page_nxt = '0;
      else                               page_nxt = page_q + PAGE_W'(1);
    end
  end

  // Both the current page and the page being switched to are needed on an advance edge.
  always_comb begin
    raw     = '0;
    new_raw = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (page_q == PAGE_W'(c))   raw     = bus.ch_data[c*LED_W +: LED_W];
      if (page_nxt == PAGE_W'(c)) new_raw = bus.ch_data[c*LED_W +: LED_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                scroll_q <= '0;
    else if (!bus.freeze) begin
      if (adv || !bus.auto_scroll)            scroll_q <= '0;
      else                                    scroll_q <= scroll_q + SCR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    page_q <= '0;
    else if (adv) page_q <= page_nxt;
  end

  for (genvar b = 0; b < LED_W; b++) begin : g_bit
    if (STRETCH_MASK[b]) begin : g_str
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset)                    cnt_q <= '0;
        else if (!bus.freeze) begin
          if (adv)                    cnt_q <= '0;
          else if (raw[b])            cnt_q <= CNT_W'(STRETCH_CYCLES);
          else if (cnt_q != '0)       cnt_q <= cnt_q - CNT_W'(1);
        end
      end

      assign led_nxt[b] = raw[b] || (cnt_q != '0);
    end else begin : g_plain
      assign led_nxt[b] = raw[b];
    end
  end

  // On an advance the new page is shown raw; stretch state never crosses pages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            led_q <= '0;
    else if (!bus.freeze) led_q <= adv ? new_raw : led_nxt;
  end

  assign bus.led      = led_q;
  assign bus.page_idx = page_q;
endmodule

// File: tb/tb_debug_led_pager.sv
// Directed and randomized checks of debug_led_pager against a sliding-window
// reference model of paging, pulse stretching, auto-scroll, freeze and reset.
module tb_debug_led_pager;
  localparam int          NUM_CH         = 4;
  localparam int          LED_W          = 16;
  localparam int          STRETCH_CYCLES = 3;
  localparam int          SCROLL_CYCLES  = 8;
  localparam logic [15:0] MASK           = 16'h9000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  debug_led_pager_if #(.NUM_CH(NUM_CH), .LED_W(LED_W)) bus();

  debug_led_pager #(
    .NUM_CH(NUM_CH), .LED_W(LED_W), .STRETCH_MASK(MASK),
    .STRETCH_CYCLES(STRETCH_CYCLES), .SCROLL_CYCLES(SCROLL_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // stimulus state
  logic [15:0] ch [NUM_CH];
  logic        pn;
  logic        au;
  logic        fr;

  // scoreboard
  int n_cmp;
  int n_err;

  // reference model: LED shows the OR of the recent raw samples of this page
  int          page_e;
  int          scr_e;
  logic [15:0] led_e;
  logic [15:0] hist [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    page_e = 0;
    scr_e  = 0;
    led_e  = '0;
    hist.delete();
  endfunction

  function automatic void model_step();
    logic [15:0] any_hi;
    if (fr) return;
    if (pn || (au && (scr_e + 1 == SCROLL_CYCLES))) begin
      page_e = (page_e + 1) % NUM_CH;
      hist.delete();
      led_e  = ch[page_e];
      scr_e  = 0;
    end else begin
      hist.push_back(ch[page_e]);
      if (hist.size() > STRETCH_CYCLES + 1) void'(hist.pop_front());
      any_hi = '0;
      foreach (hist[i]) any_hi |= hist[i];
      led_e = (any_hi & MASK) | (hist[hist.size()-1] & ~MASK);
      scr_e = au ? scr_e + 1 : 0;
    end
  endfunction

  // driver: apply inputs, take one edge, compare against the model
  task automatic tick();
    bus.ch_data     = {ch[3], ch[2], ch[1], ch[0]};
    bus.page_next   = pn;
    bus.auto_scroll = au;
    bus.freeze      = fr;
    @(posedge clk);
    model_step();
    #1;
    check("model_led", 32'(bus.led), 32'(led_e));
    check("model_page", 32'(bus.page_idx), 32'(page_e));
    pn = 1'b0;
  endtask

  task automatic pulse_run(input logic [15:0] pat, input int p2, input int b, output int hi);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      ch[0] = (i == 0 || i == p2) ? pat : 16'h0000;
      tick();
      hi += int'(bus.led[b]);
    end
  endtask

  logic [15:0] pg_seq [5];
  int          hi;
  int          exp_pg;

  initial begin
    pg_seq = '{16'h00A5, 16'h0F0F, 16'h1234, 16'h0001, 16'h00A5};
    foreach (ch[j]) ch[j] = '0;
    pn = 1'b0; au = 1'b0; fr = 1'b0;
    n_cmp = 0; n_err = 0;
    bus.ch_data = '0; bus.page_next = 1'b0; bus.auto_scroll = 1'b0; bus.freeze = 1'b0;
    model_reset();

    // reset state
    #12;
    check("reset_led", 32'(bus.led), 32'h0);
    check("reset_page", 32'(bus.page_idx), 32'h0);
    reset = 1'b0;

    // paging with wrap
    ch[0] = 16'h00A5; ch[1] = 16'h0F0F; ch[2] = 16'h1234; ch[3] = 16'h0001;
    tick();
    check("page0_led", 32'(bus.led), 32'h00A5);
    for (int i = 1; i < 5; i++) begin
      pn = 1'b1;
      tick();
      check("paging_led", 32'(bus.led), 32'(pg_seq[i]));
      check("paging_idx", 32'(bus.page_idx), 32'(i % 4));
    end

    // stretch: single pulse, unstretched bit, retrigger
    ch[0] = 16'h0000;
    tick();
    pulse_run(16'h8000, 0, 15, hi);
    check("stretch_len15", 32'(hi), 32'd4);
    pulse_run(16'h0001, 0, 0, hi);
    check("plain_len0", 32'(hi), 32'd1);
    pulse_run(16'h8000, 2, 15, hi);
    check("retrigger_len15", 32'(hi), 32'd6);

    // auto-scroll period
    au = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      check("auto_idx", 32'(bus.page_idx), 32'((c / 8) % 4));
    end
    au = 1'b0;
    tick();
    for (int i = 0; i < NUM_CH && page_e != 0; i++) begin
      pn = 1'b1;
      tick();
    end

    // manual pulse restarts the period; pulse on terminal count steps once
    au = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      pn = (c == 12 || c == 28);
      tick();
      exp_pg = (c < 8) ? 0 : (c < 12) ? 1 : (c < 20) ? 2 : (c < 28) ? 3 : 0;
      check("scroll_pn_idx", 32'(bus.page_idx), 32'(exp_pg));
    end
    au = 1'b0;
    tick();

    // freeze holds display and drops pulses
    ch[0] = 16'h00A5;
    tick();
    fr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ch[0] = 16'($urandom);
      pn = (i % 2 == 0);
      tick();
      check("freeze_led", 32'(bus.led), 32'h00A5);
      check("freeze_idx", 32'(bus.page_idx), 32'h0);
    end
    fr = 1'b0;
    ch[0] = 16'h5A5A;
    tick();
    check("unfreeze_led", 32'(bus.led), 32'h5A5A);
    check("unfreeze_idx", 32'(bus.page_idx), 32'h0);

    // page change discards stretch
    ch[0] = 16'h8000; ch[1] = 16'h0000;
    tick();
    check("pre_adv_led15", 32'(bus.led[15]), 32'h1);
    ch[0] = 16'h0000;
    pn = 1'b1;
    tick();
    check("adv_clear_led", 32'(bus.led), 32'h0);
    check("adv_clear_idx", 32'(bus.page_idx), 32'h1);

    // async reset mid-stretch on page 2 with auto-scroll running
    pn = 1'b1;
    tick();
    au = 1'b1;
    ch[2] = 16'h8000;
    tick();
    ch[2] = 16'h0000;
    tick();
    check("prereset_led15", 32'(bus.led[15]), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_led", 32'(bus.led), 32'h0);
    check("async_reset_idx", 32'(bus.page_idx), 32'h0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      check("post_reset_idx", 32'(bus.page_idx), (c >= 8) ? 32'h1 : 32'h0);
    end

    // randomized traffic against the model
    au = 1'b0;
    fr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      foreach (ch[j]) if ($urandom_range(0, 3) == 0) ch[j] = 16'($urandom);
      pn = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) au = ~au;
      if ($urandom_range(0, 11) == 0) fr = ~fr;
      tick();
    end

    // report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
